// File: rtl/rtc_pkg.sv
// Shared constants and types for the RTC seven-segment scanner: segment patterns,
// digit-slot enumeration and the BCD time-validity check.
package rtc_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  typedef enum logic [2:0] {
    SECL = 3'd0,
    SECM = 3'd1,
    MINL = 3'd2,
    MINM = 3'd3,
    HRL  = 3'd4,
    HRM  = 3'd5
  } digit_idx_e;

  // Element k holds the digit shown in slot k, so the scan index selects it directly.
  typedef logic [NUM_DIGITS-1:0][3:0] time_bcd_t;

  function automatic logic time_invalid(input time_bcd_t t);
    logic bad;
    bad = (t[SECL] > 4'd9) || (t[MINL] > 4'd9) || (t[HRL] > 4'd9) ||
          (t[SECM] > 4'd5) || (t[MINM] > 4'd5) || (t[HRM] > 4'd2) ||
          ((t[HRM] == 4'd2) && (t[HRL] > 4'd3));
    return bad;
  endfunction

endpackage

// File: rtl/rtc_seg_scan_if.sv
// Time digits into the scanner and multiplexed display drive out of it.
interface rtc_seg_scan_if;
  logic [3:0] hrm, hrl, minm, minl, secm, secl;
  logic [6:0] seg;
  logic [5:0] an;
  logic       dp;
  logic       frame_done;
  logic       err;

  modport master (
    output hrm, hrl, minm, minl, secm, secl,
    input  seg, an, dp, frame_done, err
  );

  modport slave (
    input  hrm, hrl, minm, minl, secm, secl,
    output seg, an, dp, frame_done, err
  );
endinterface

// File: rtl/bcd_to_seg.sv
// Combinational BCD to {g,f,e,d,c,b,a} decode; non-decimal codes show a dash.
module bcd_to_seg
  import rtc_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/rtc_seg_scan.sv
// Six-digit multiplexed display scanner: frame-latched time snapshot, one-cycle
// registered outputs, ghost blanking on slot 0 of every digit; free-running, no backpressure.
module rtc_seg_scan
  import rtc_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int LZB   = 1
) (
  input logic           hundred_clk,
  input logic           rst,
  rtc_seg_scan_if.slave bus
);

  localparam logic [7:0] SLOT_LAST = 8'(DWELL - 1);

  digit_idx_e r_idx, w_idx_nxt;
  logic [7:0] r_slot, w_slot_nxt;
  time_bcd_t  r_snap, w_live;
  logic [6:0] r_seg, w_seg_nxt, w_seg_dec;
  logic [5:0] r_an, w_an_nxt;
  logic       r_dp, w_dp_nxt;
  logic       r_frame_done, w_fd_nxt;
  logic       r_err;
  logic       w_slot_last, w_cap, w_lead_blank;

  assign w_live       = {bus.hrm, bus.hrl, bus.minm, bus.minl, bus.secm, bus.secl};
  assign w_slot_last  = (r_slot == SLOT_LAST);
  assign w_cap        = (r_idx == SECL) && (r_slot == 8'd0);
  assign w_lead_blank = (LZB != 0) && (r_idx == HRM) && (r_snap[HRM] == 4'd0);

  bcd_to_seg u_dec (
    .i_bcd (r_snap[r_idx]),
    .o_seg (w_seg_dec)
  );

  always_comb begin
    w_slot_nxt = r_slot + 8'd1;
    w_idx_nxt  = r_idx;
    if (w_slot_last) begin
      w_slot_nxt = 8'd0;
      w_idx_nxt  = (r_idx == HRM) ? SECL : digit_idx_e'(r_idx + 3'd1);
    end

    // Slot 0 of each digit stays dark so the previous digit's segments never ghost.
    w_an_nxt  = 6'b111111;
    w_seg_nxt = SEG_OFF;
    w_dp_nxt  = 1'b0;
    w_fd_nxt  = (r_idx == HRM) && w_slot_last;
    if (r_slot != 8'd0) begin
      w_an_nxt  = ~(6'b000001 << r_idx);
      w_seg_nxt = w_lead_blank ? SEG_OFF : w_seg_dec;
      w_dp_nxt  = ((r_idx == MINL) || (r_idx == HRL)) && !r_snap[SECL][0];
    end
  end

  always_ff @(posedge hundred_clk) begin
    if (!rst) begin
      r_idx        <= SECL;
      r_slot       <= 8'd0;
      r_snap       <= '0;
      r_an         <= 6'b111111;
      r_seg        <= SEG_OFF;
      r_dp         <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_idx        <= w_idx_nxt;
      r_slot       <= w_slot_nxt;
      r_an         <= w_an_nxt;
      r_seg        <= w_seg_nxt;
      r_dp         <= w_dp_nxt;
      r_frame_done <= w_fd_nxt;
      if (w_cap) begin
        r_snap <= w_live;
        if (time_invalid(w_live)) r_err <= 1'b1;
      end
    end
  end

  assign bus.seg        = r_seg;
  assign bus.an         = r_an;
  assign bus.dp         = r_dp;
  assign bus.frame_done = r_frame_done;
  assign bus.err        = r_err;

endmodule

// File: doc/rtc_seg_scan.md
RTC_SEG_SCAN -- requirements
Module: rtc_seg_scan

Interface
REQ-001 Parameter DWELL, default 4, SHALL set the hundred_clk cycles per digit slot; the legal range is 2..255.
REQ-002 Parameter LZB, default 1, SHALL enable blanking of the leading hours digit when it is zero (1 = blank, 0 = show "0").
REQ-003 hundred_clk  input  1  SHALL be the clock; all logic is on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 hrm, hrl, minm, minl, secm, secl  input  4 each  SHALL carry the BCD time digits from the RTC counter chain, in the same clock domain.
REQ-006 seg  output  7  SHALL carry the segments {g,f,e,d,c,b,a}, active-high.
REQ-007 an  output  6  SHALL carry the digit enables, active-low; bit k drives digit slot k.
REQ-008 dp  output  1  SHALL drive the decimal point / colon, active-high.
REQ-009 frame_done  output  1  SHALL be a one-cycle pulse at the end of each complete 6-digit scan.
REQ-010 err  output  1  SHALL be a sticky flag for an invalid time digit.

Function
REQ-011 Slot counter SHALL count 0..DWELL-1, then wrap to 0 and advance the digit index.
REQ-012 Digit index SHALL count 0..5, wrap 5->0, and map to: 0=secl, 1=secm, 2=minl, 3=minm, 4=hrl, 5=hrm.
REQ-013 Snapshot SHALL capture a 24-bit copy of all six digits in any cycle with index==0 && slot==0.
  - This includes the first cycle after reset release.
  - Digit values SHALL NOT change mid-frame (no tearing).
REQ-014 Display SHALL decode only from the snapshot, never from the live inputs.
REQ-015 Outputs seg, an, dp and frame_done SHALL be registered, with exactly one cycle of latency from the (index, slot) state.
REQ-016 Ghost blanking: when slot==0, the next-cycle an SHALL be 6'b111111, seg 0 and dp 0.
REQ-017 When slot is 1..DWELL-1, an SHALL be ~(6'b1 << index) and seg SHALL be the decode of the snapshot digit.
REQ-018 Decoding SHALL map:
  - 0..9 -> standard common patterns (0=7'h3F, 1=7'h06, 8=7'h7F).
  - 10..15 -> dash 7'h40.
REQ-019 When LZB=1, index==5 and snapshot hrm==0, seg SHALL be 0 while an still enables digit 5.
REQ-020 dp SHALL be 1 on driven cycles of index 2 or 4 when snapshot secl[0]==0, and 0 otherwise; the colon blinks at the seconds rate.
REQ-021 frame_done SHALL be asserted on the output cycle following the state index==5, slot==DWELL-1.
REQ-022 err SHALL be set at a snapshot capture if any of the following holds, and SHALL stay set until reset:
  - any digit >9;
  - secm >5 or minm >5;
  - hrm >2;
  - hrm==2 && hrl >3.
REQ-023 An input change in the cycle of a snapshot capture SHALL be taken as the value sampled on that edge; it SHALL NOT be re-sampled until the next frame.
REQ-024 Frame period SHALL be exactly 6*DWELL cycles, with no idle cycles between frames.

Reset
REQ-025 While rst==0 at a clock edge, all of the following SHALL be cleared on that edge:
  - index=0, slot=0, snapshot=0;
  - an=6'b111111, seg=0, dp=0, frame_done=0, err=0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no frame_done pulse; scanning SHALL restart at index 0 and take a fresh snapshot on the first cycle with rst==1.
REQ-027 Inputs SHALL be ignored while in reset.

Structure
REQ-028 Shared package rtc_pkg SHALL hold:
  - NUM_DIGITS=6;
  - the ten digit segment constants, SEG_DASH and SEG_OFF;
  - the digit-index enumeration (SECL..HRM).
REQ-029 One combinational sub-module, bcd_to_seg (4-bit in, 7-bit out, using the REQ-018 map), SHALL be instantiated once in rtc_seg_scan.
REQ-030 Implementation size SHALL be 120-400 lines of RTL, with no latches and no derived clocks.

Verification (DWELL=4, LZB=1 unless stated)
REQ-031 Reset release with inputs 12:34:56:
  - an sequence per frame: 111111,111110x3, 111111,111101x3, ... ,011111x3;
  - seg per digit slot: 6,5,4,3,2,1;
  - frame_done pulses every 24 cycles.
REQ-032 Inputs change from 12:34:56 to 12:34:57 at frame cycle 10:
  - the current frame still shows ...6;
  - the next frame shows 7;
  - dp is lit on slots 2/4 in the 56 frame and dark in the 57 frame.
REQ-033 Inputs 09:05:00 with LZB=1: slot 5 seg=0 and an=011111. Same inputs with LZB=0: slot 5 seg=7'h3F.
REQ-034 Inputs with hrl=4'hB:
  - slot 4 seg=7'h40;
  - err rises one cycle after that snapshot capture and stays 1 after the inputs return valid;
  - err clears only when rst=0.
REQ-035 rst=0 for one cycle at frame cycle 13:
  - next cycle an=111111 and seg=0;
  - no frame_done pulse for the aborted frame;
  - the next frame_done comes 24 cycles after the rst=1 cycle.
REQ-036 Inputs 23:59:59 -> 00:00:00 at a frame boundary:
  - the snapshot captures the new value;
  - slot 5 is blanked (LZB);
  - err stays 0.
